ysyx_25040105_ifu: RTL and testbench
====================================

Name: ysyx_25040105_ifu

Overview:
- Instruction fetch unit, directly upstream of the decode stage.
- Holds the architectural PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Captures the returned 32-bit word and presents it, with its PC and an error flag, to the decoder over a valid/ready handshake.
- Accepts redirects (taken jumps, i.e. JAL/JALR results from execute) at any time; stale in-flight data is squashed.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address (= pc)
- imem_rsp_valid  input  1  read data valid, one cycle pulse per accepted request
- imem_rsp_data  input  32  instruction word
- imem_rsp_err  input  1  access fault for this response
- redirect_valid  input  1  load redirect_pc, squash current fetch
- redirect_pc  input  XLEN  redirect target
- out_valid  output  1  instruction valid to decoder
- out_ready  input  1  decoder accepts instruction
- out_inst  output  32  instruction word
- out_pc  output  XLEN  PC of out_inst
- out_err  output  1  fetch fault (bus error or misaligned PC)
- fetch_cnt  output  32  count of instructions delivered (out handshakes)

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, pc=RESET_PC, kill=0, imem_req_valid=0, out_valid=0, out_inst=0, out_pc=RESET_PC, out_err=0, fetch_cnt=0.
- Output decode: imem_req_valid=1 only in REQ. out_valid=1 only in HOLD. Both are decoded from registered state (no input-to-output combinational paths except none).
- IDLE: next cycle -> REQ. If pc[1:0]!=0 -> HOLD with out_err=1, out_inst=32'h0000_0013, out_pc=pc, no memory request.
- REQ: imem_req_addr=pc, held stable until imem_req_ready. On imem_req_ready -> WAIT.
- WAIT: on imem_rsp_valid with kill=0 -> HOLD, out_inst=imem_rsp_data, out_pc=pc, out_err=imem_rsp_err.
  - If imem_rsp_err=1, out_inst=32'h0000_0013.
  - On imem_rsp_valid with kill=1 -> drop data, clear kill, -> IDLE.
- HOLD: on out_ready -> pc<=pc+4 (mod 2^32, wraps from FFFF_FFFC to 0), fetch_cnt<=fetch_cnt+1 (wraps), -> IDLE.
- Latency: with zero-wait memory (req_ready=1, rsp one cycle after acceptance), the sequence is IDLE, REQ (accept), WAIT (rsp), HOLD. First out_valid is the 4th cycle after reset release. Steady throughput is 1 instruction per 4 cycles.
- Redirect (priority over everything; pc<=redirect_pc):
  - IDLE: goes via IDLE alignment check next cycle (stays IDLE one cycle).
  - REQ, no req_ready: -> IDLE (request withdrawn).
  - REQ, with req_ready same cycle: request is consumed, set kill=1, -> WAIT.
  - WAIT: set kill=1, stay WAIT. If rsp_valid same cycle, drop rsp, -> IDLE, kill=0.
  - HOLD without out_ready: held instruction discarded, out_valid=0 next cycle, -> IDLE, fetch_cnt unchanged.
  - HOLD with out_ready same cycle: instruction counts as delivered (fetch_cnt+1), pc<=redirect_pc (not pc+4), -> IDLE.
- At most one outstanding memory request. A response arriving outside WAIT is ignored.
- Reset asserted mid-transaction: immediate return to reset values. Any later stray response is ignored (state is not WAIT).

Test Plan:
- Reset release, zero-wait memory returning 32'h00000093 then 32'h00100113 -> out_pc 80000000 then 80000004. out_valid first high 4 cycles after release. fetch_cnt=2.
- out_ready held 0 for 5 cycles in HOLD -> out_valid, out_inst, out_pc stable. imem_req_valid=0 throughout. No pc change.
- Redirect to 80000100 in WAIT; response 32'hDEADBEEF arrives 2 cycles later -> response dropped. Next request addr=80000100. Next out_pc=80000100.
- Redirect to 80000200 in the same cycle as the HOLD handshake -> fetch_cnt increments once. Next imem_req_addr=80000200, not pc+4.
- imem_rsp_err=1 on fetch at 80000008 -> out_err=1, out_inst=00000013, out_pc=80000008. Redirect to 80000002 -> no imem request, out_err=1, out_pc=80000002.
- rst_n pulled low in WAIT, response arrives during/after reset -> all outputs return to reset values. The first new request is at RESET_PC.

Source files
------------

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and hands
// the fetched word (with its PC and fault flag) to decode over valid/ready.
module ysyx_25040105_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_err_q, out_err_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_err_d   = out_err_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (pc_q[1:0] != 2'b00) begin
          // Misaligned PC faults locally without touching memory.
          state_d    = S_HOLD;
          out_inst_d = NOP;
          out_pc_d   = pc_q;
          out_err_d  = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_rsp_valid) begin
          if (redirect_valid || kill_q) begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d    = S_HOLD;
            out_inst_d = imem_rsp_err ? NOP : imem_rsp_data;
            out_pc_d   = pc_q;
            out_err_d  = imem_rsp_err;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (out_ready) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (redirect_valid)  pc_d = redirect_pc;
        else if (out_ready)  pc_d = pc_q + XLEN'(4);
        if (redirect_valid || out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_inst_q  <= 32'h0;
      out_pc_q    <= RESET_PC;
      out_err_q   <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_err_q   <= out_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_HOLD);
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;
  assign out_err        = out_err_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized phase checked
// against a transaction-level model of the architectural PC and delivery count.
module tb_ysyx_25040105_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic [31:0] fetch_cnt;

  ysyx_25040105_ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_err(out_err), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory contents as seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0093;
      32'h8000_0004: return 32'h0010_0113;
      default:       return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
    endcase
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'h2;
  endfunction

  // Responder knobs and state.
  int          lat_fix    = 1;
  int          lat_max    = 3;
  bit          ready_rand = 0;
  bit          ready_block = 0;
  bit          stray_en   = 0;
  bit          ovr_en     = 0;
  logic [31:0] ovr_data   = '0;
  bit          pend_on    = 0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = '0;

  // Reference model: architectural PC and delivered count.
  logic [31:0] m_pc  = RESET_PC;
  logic [31:0] m_cnt = '0;
  int          n_accepts = 0;
  int          n_deliv   = 0;
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_inst[$];

  // Samples of the cycle just finished.
  logic        s_req_valid, s_out_valid, s_out_err, s_accept;
  logic [31:0] s_out_inst, s_out_pc, s_fetch_cnt, s_acc_addr;

  task automatic monitor();
    bit          hs;
    logic        exp_err;
    logic [31:0] exp_inst;
    s_req_valid = imem_req_valid;
    s_out_valid = out_valid;
    s_out_inst  = out_inst;
    s_out_pc    = out_pc;
    s_out_err   = out_err;
    s_fetch_cnt = fetch_cnt;
    s_accept    = imem_req_valid && imem_req_ready;
    hs          = out_valid && out_ready;
    if (!rst_n) begin
      m_pc  = RESET_PC;
      m_cnt = '0;
    end else begin
      check("m_fetch_cnt", fetch_cnt, m_cnt);
      if (imem_req_valid) check("m_req_addr", imem_req_addr, m_pc);
      if (out_valid) begin
        exp_err  = (m_pc[1:0] != 2'b00) || mem_err(m_pc);
        exp_inst = exp_err ? NOP : mem_word(m_pc);
        check("m_out_pc", out_pc, m_pc);
        check("m_out_inst", out_inst, exp_inst);
        check("m_out_err", 32'(out_err), 32'(exp_err));
      end
      if (s_accept) begin
        n_accepts++;
        s_acc_addr = imem_req_addr;
        pend_on    = 1;
        pend_cnt   = (lat_fix > 0) ? lat_fix : $urandom_range(1, lat_max);
        pend_addr  = imem_req_addr;
      end
      if (hs) begin
        m_cnt = m_cnt + 32'd1;
        n_deliv++;
        deliv_pc.push_back(out_pc);
        deliv_inst.push_back(out_inst);
      end
      if (redirect_valid) m_pc = redirect_pc;
      else if (hs)        m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive_mem();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'($urandom_range(0, 1));
    if (pend_on) begin
      if (pend_cnt > 1) pend_cnt--;
      else begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ovr_en ? ovr_data : mem_word(pend_addr);
        imem_rsp_err   = ovr_en ? 1'b0 : mem_err(pend_addr);
        ovr_en  = 0;
        pend_on = 0;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    imem_req_ready = ready_block ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  // One clock: sample/model at negedge, then drive memory just after posedge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic wait_for(input bit want_accept, input string tag);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (want_accept ? s_accept : s_out_valid) begin
        ok = 1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(s_req_valid), 32'd0);
    check({tag, "_out_valid"}, 32'(s_out_valid), 32'd0);
    check({tag, "_out_inst"},  s_out_inst, 32'd0);
    check({tag, "_out_pc"},    s_out_pc, RESET_PC);
    check({tag, "_out_err"},   32'(s_out_err), 32'd0);
    check({tag, "_fetch_cnt"}, s_fetch_cnt, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc0, inst0, cnt0, tgt;
    int          acc0, deliv0;

    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    tick();
    tick();
    check_reset_outputs("rst");

    // Zero-wait fetch of the first two words, first valid on the 4th cycle.
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lat_c%0d", i + 1), 32'(s_out_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    tick();
    check("t1_fetch_cnt", s_fetch_cnt, 32'd2);
    check("t1_pc0", deliv_pc[0], 32'h8000_0000);
    check("t1_pc1", deliv_pc[1], 32'h8000_0004);
    check("t1_inst0", deliv_inst[0], 32'h0000_0093);
    check("t1_inst1", deliv_inst[1], 32'h0010_0113);

    // Stall in HOLD; this fetch at 80000008 also returns a bus error.
    wait_for(0, "t2_valid");
    pc0   = s_out_pc;
    inst0 = s_out_inst;
    check("t2_pc", pc0, 32'h8000_0008);
    check("t2_err", 32'(s_out_err), 32'd1);
    check("t2_inst", inst0, NOP);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", 32'(s_out_valid), 32'd1);
      check("t2_stall_pc", s_out_pc, pc0);
      check("t2_stall_inst", s_out_inst, inst0);
      check("t2_stall_req", 32'(s_req_valid), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Redirect while waiting; the late DEADBEEF response must be dropped.
    lat_fix  = 3;
    ovr_en   = 1;
    ovr_data = 32'hDEAD_BEEF;
    wait_for(1, "t3_acc0");
    pulse_redirect(32'h8000_0100);
    lat_fix = 1;
    wait_for(1, "t3_acc1");
    check("t3_req_addr", s_acc_addr, 32'h8000_0100);
    wait_for(0, "t3_valid");
    check("t3_out_pc", s_out_pc, 32'h8000_0100);
    check("t3_out_inst", s_out_inst, mem_word(32'h8000_0100));

    // Redirect coinciding with the delivery handshake.
    cnt0 = s_fetch_cnt;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    tick();
    check("t4_cnt", s_fetch_cnt, cnt0 + 32'd1);
    wait_for(1, "t4_acc");
    check("t4_req_addr", s_acc_addr, 32'h8000_0200);
    wait_for(0, "t4_valid");
    check("t4_cnt_once", s_fetch_cnt, cnt0 + 32'd1);

    // Redirect to a misaligned target discards the held word, no memory access.
    pulse_redirect(32'h8000_0002);
    acc0 = n_accepts;
    wait_for(0, "t5_valid");
    check("t5_out_pc", s_out_pc, 32'h8000_0002);
    check("t5_out_err", 32'(s_out_err), 32'd1);
    check("t5_out_inst", s_out_inst, NOP);
    check("t5_no_req", 32'(n_accepts - acc0), 32'd0);
    check("t5_cnt_kept", s_fetch_cnt, cnt0 + 32'd1);

    // PC wraps past the top of the address space.
    pulse_redirect(32'hFFFF_FFFC);
    wait_for(0, "wrap_valid");
    check("wrap_out_pc", s_out_pc, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_for(1, "wrap_acc");
    check("wrap_req_addr", s_acc_addr, 32'h0000_0000);

    // Reset in WAIT with the response landing after release.
    wait_for(0, "t6_valid0");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    lat_fix = 4;
    wait_for(1, "t6_acc0");
    rst_n       = 1'b0;
    ready_block = 1;
    tick();
    check_reset_outputs("t6_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t6_stray_sent", 32'(pend_on), 32'd0);
    check("t6_after_valid", 32'(s_out_valid), 32'd0);
    check("t6_after_cnt", s_fetch_cnt, 32'd0);
    ready_block = 0;
    lat_fix     = 1;
    wait_for(1, "t6_acc1");
    check("t6_req_addr", s_acc_addr, RESET_PC);
    wait_for(0, "t6_valid1");
    check("t6_out_pc", s_out_pc, RESET_PC);

    // Randomized traffic checked by the model in monitor().
    lat_fix    = 0;
    lat_max    = 3;
    ready_rand = 1;
    stray_en   = 1;
    deliv0     = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 15))
          0:       tgt = RESET_PC + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
          1:       tgt = 32'hFFFF_FFF8;
          default: tgt = RESET_PC + 32'($urandom_range(0, 63) * 4);
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end
      tick();
      redirect_valid = 1'b0;
    end
    check("rand_progress", 32'(n_deliv - deliv0 >= 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
